// File: rtl/fir_mc_seq.sv
// fir_mc_seq: time-multiplexed multi-channel FIR, one shared MAC, runtime coefficients, valid/ready streaming
// Ports: clk/rst (async, active-high); in_valid/in_data/in_chan/in_ready sample input;
// out_valid/out_data/out_chan/out_ready result output; coef_we/coef_addr/coef_data coefficient load (IDLE only);
// err_chan one-cycle pulse when an accepted sample names a channel that does not exist.
module fir_mc_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 38,
  parameter int COEFF_COUNT = 64,
  parameter int CHANNELS    = 2,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(COEFF_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [CW-1:0]                in_chan,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic [CW-1:0]                out_chan,
  input  logic                         out_ready,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_data,
  output logic                         err_chan
);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam logic [CW:0]   CH_LIM = (CW+1)'(CHANNELS);
  localparam logic [AW-1:0] K_LAST = AW'(COEFF_COUNT - 1);
  state_t r_state, w_next;
  logic r_up, r_err;
  logic [AW-1:0] r_k, w_addr;
  logic [CW-1:0] r_ch;
  logic signed [OUT_WIDTH-1:0] r_acc, w_prod_x;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [DATA_WIDTH-1:0] r_coef [COEFF_COUNT];
  logic signed [DATA_WIDTH-1:0] r_hist [CHANNELS][COEFF_COUNT];
  logic [AW-1:0] r_ptr [CHANNELS];
  logic w_hs, w_take;
  // r_up keeps in_ready low until the first edge after reset release
  assign in_ready  = r_up && r_state == IDLE;
  assign out_valid = r_state == OUT;
  assign out_data  = r_acc;
  assign out_chan  = r_ch;
  assign err_chan  = r_err;
  assign w_hs   = in_valid && in_ready;
  assign w_take = w_hs && ({1'b0, in_chan} < CH_LIM);
  // the newest sample sits one slot behind the write pointer; tap k reaches k further back
  assign w_addr   = r_ptr[r_ch] - r_k - AW'(1);
  assign w_prod   = (2*DATA_WIDTH)'(r_coef[r_k]) * (2*DATA_WIDTH)'(r_hist[r_ch][w_addr]);
  assign w_prod_x = OUT_WIDTH'(w_prod);
  always_comb begin
    w_next = (r_state == IDLE && w_take)       ? MAC  :
             (r_state == MAC && r_k == K_LAST) ? OUT  :
             (r_state == OUT && out_ready)     ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_up    <= 1'b0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_ch    <= '0;
      r_acc   <= '0;
      for (int i = 0; i < COEFF_COUNT; i++) r_coef[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_ptr[c] <= '0;
        for (int i = 0; i < COEFF_COUNT; i++) r_hist[c][i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_up    <= 1'b1;
      r_err   <= w_hs && !w_take;
      if (r_state == IDLE && coef_we) r_coef[coef_addr] <= coef_data;
      if (w_take) begin
        r_hist[in_chan][r_ptr[in_chan]] <= in_data;
        r_ptr[in_chan] <= r_ptr[in_chan] + AW'(1);
        r_acc <= '0;
        r_k   <= '0;
        r_ch  <= in_chan;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + w_prod_x;
        r_k   <= r_k + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fir_mc_seq.sv
// tb_fir_mc_seq: self-checking bench for fir_mc_seq (default build plus a 3-channel, 4-tap build)
module tb_fir_mc_seq;
  localparam int N  = 64;
  localparam int N3 = 4;
  typedef struct {int ch; int x; longint exp;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b1, coef_we = 1'b0;
  logic in_ready, out_valid, err_chan;
  logic signed [15:0] in_data = '0, coef_data = '0;
  logic [0:0] in_chan = '0, out_chan;
  logic signed [37:0] out_data;
  logic [5:0] coef_addr = '0;
  logic in_valid3 = 1'b0, out_ready3 = 1'b1, coef_we3 = 1'b0;
  logic in_ready3, out_valid3, err_chan3;
  logic signed [15:0] in_data3 = '0, coef_data3 = '0;
  logic [1:0] in_chan3 = '0, out_chan3;
  logic signed [37:0] out_data3;
  logic [1:0] coef_addr3 = '0;
  int n_chk = 0, n_pass = 0;
  longint h[N];
  int xq[2][$];
  vec_t tv[$];
  fir_mc_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_chan(in_chan), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .err_chan(err_chan)
  );
  fir_mc_seq #(.COEFF_COUNT(N3), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3), .in_chan(in_chan3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3), .out_ready(out_ready3),
    .coef_we(coef_we3), .coef_addr(coef_addr3), .coef_data(coef_data3), .err_chan(err_chan3)
  );
  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask
  function automatic void model_push(int ch, int x);
    xq[ch].push_front(x);
    if (xq[ch].size() > N) void'(xq[ch].pop_back());
  endfunction
  function automatic longint model_y(int ch);
    longint s = 0;
    for (int k = 0; k < xq[ch].size(); k++) s += h[k] * longint'(xq[ch][k]);
    return s;
  endfunction
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic load_h();
    for (int k = 0; k < N; k++) begin
      coef_we = 1'b1;
      coef_addr = 6'(k);
      coef_data = 16'(h[k]);
      cycle();
    end
    coef_we = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    for (int c = 0; c < 2; c++) xq[c].delete();
    for (int k = 0; k < N; k++) h[k] = 0;
  endtask
  task automatic send(input int ch, input int x, output longint got, output int gch, output int lat);
    int t = 0;
    while (!in_ready && t < 200) begin
      cycle();
      t++;
    end
    in_valid = 1'b1;
    in_chan = 1'(ch);
    in_data = 16'(x);
    cycle();
    in_valid = 1'b0;
    model_push(ch, x);
    chk("err_chan_quiet", longint'(err_chan), 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      cycle();
      lat++;
    end
    got = longint'(out_data);
    gch = int'(out_chan);
    cycle();
  endtask
  task automatic run(input string name, input int ch, input int x, input longint exp);
    longint got;
    int gch, lat;
    send(ch, x, got, gch, lat);
    chk(name, got, exp);
    chk({name, "_chan"}, gch, ch);
    chk({name, "_latency"}, lat, N);
    chk({name, "_in_ready_back"}, longint'(in_ready), 1);
  endtask
  task automatic send3(input int ch, input int x, output longint got);
    int lat = 0;
    in_valid3 = 1'b1;
    in_chan3 = 2'(ch);
    in_data3 = 16'(x);
    cycle();
    in_valid3 = 1'b0;
    chk("c3_err_quiet", longint'(err_chan3), 0);
    while (!out_valid3 && lat < 50) begin
      cycle();
      lat++;
    end
    chk("c3_latency", lat, N3);
    chk("c3_chan", longint'(out_chan3), ch);
    got = longint'(out_data3);
    cycle();
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    longint got, bexp;
    int gch, lat, t, ch, x;
    bit quiet;
    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_chan", longint'(out_chan), 0);
    chk("rst_err_chan", longint'(err_chan), 0);
    chk("rst_in_ready3", longint'(in_ready3), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    chk("in_ready_after_reset", longint'(in_ready), 1);
    // impulse response through a table of expected outputs
    for (int k = 0; k < N; k++) h[k] = k + 1;
    load_h();
    for (int i = 0; i < N + 1; i++) tv.push_back('{0, (i == 0) ? 1 : 0, (i < N) ? longint'(i + 1) : 0});
    foreach (tv[i]) run("impulse", tv[i].ch, tv[i].x, tv[i].exp);
    // step with negative coefficients
    do_reset();
    for (int k = 0; k < N; k++) h[k] = -2;
    load_h();
    for (int i = 0; i < N + 6; i++) run("step", 0, 3, -6 * longint'((i < N) ? i + 1 : N));
    // channel independence
    do_reset();
    for (int k = 0; k < N; k++) h[k] = 1;
    load_h();
    for (int i = 0; i < N + 2; i++) begin
      run("ind_ch0", 0, (i == 0) ? 1 : 0, (i < N) ? 1 : 0);
      run("ind_ch1", 1, 5, 5 * longint'((i < N) ? i + 1 : N));
    end
    // random coefficients and samples against the reference model
    for (int k = 0; k < N; k++) h[k] = longint'($signed(16'($urandom)));
    load_h();
    for (int i = 0; i < 30; i++) begin
      ch = int'($urandom_range(0, 1));
      x = int'($signed(16'($urandom)));
      send(ch, x, got, gch, lat);
      chk("rand_data", got, model_y(ch));
      chk("rand_chan", gch, ch);
      chk("rand_latency", lat, N);
    end
    // backpressure with ignored coefficient writes during MAC and OUT
    out_ready = 1'b0;
    x = int'($signed(16'($urandom)));
    in_valid = 1'b1;
    in_chan = 1'b1;
    in_data = 16'(x);
    cycle();
    in_valid = 1'b0;
    model_push(1, x);
    bexp = model_y(1);
    for (int i = 0; i < 5; i++) begin
      coef_we = 1'b1;
      coef_addr = 6'd0;
      coef_data = 16'sh7fff;
      cycle();
    end
    coef_we = 1'b0;
    t = 0;
    while (!out_valid && t < 200) begin
      cycle();
      t++;
    end
    chk("bp_valid", longint'(out_valid), 1);
    coef_we = 1'b1;
    coef_addr = 6'd1;
    coef_data = -16'sd1234;
    cycle();
    coef_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data", longint'(out_data), bexp);
      chk("bp_hold_valid", longint'(out_valid), 1);
      chk("bp_in_ready_low", longint'(in_ready), 0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_valid", longint'(out_valid), 0);
    chk("bp_release_ready", longint'(in_ready), 1);
    x = int'($signed(16'($urandom)));
    send(1, x, got, gch, lat);
    chk("bp_old_coefs", got, model_y(1));
    // asynchronous reset in the middle of the MAC
    in_valid = 1'b1;
    in_chan = 1'b0;
    in_data = 16'sd100;
    cycle();
    in_valid = 1'b0;
    repeat (30) cycle();
    chk("mid_mac_valid", longint'(out_valid), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_mac_rst_ready", longint'(in_ready), 0);
    chk("mid_mac_rst_valid", longint'(out_valid), 0);
    chk("mid_mac_rst_data", longint'(out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    chk("mid_mac_ready_back", longint'(in_ready), 1);
    for (int c = 0; c < 2; c++) xq[c].delete();
    for (int k = 0; k < N; k++) h[k] = longint'($signed(16'($urandom)));
    load_h();
    run("post_reset_ch0_h0", 0, 1, h[0]);
    run("post_reset_ch1_h0", 1, 1, h[0]);
    // invalid channel on the 3-channel build
    for (int k = 0; k < N3; k++) begin
      coef_we3 = 1'b1;
      coef_addr3 = 2'(k);
      coef_data3 = (k == 0) ? 16'sd3 : (k == 1) ? -16'sd5 : (k == 2) ? 16'sd7 : 16'sd9;
      cycle();
    end
    coef_we3 = 1'b0;
    send3(2, 7, got);
    chk("c3_ch2_first", got, 21);
    send3(1, 4, got);
    chk("c3_ch1_first", got, 12);
    in_valid3 = 1'b1;
    in_chan3 = 2'd3;
    in_data3 = 16'sd1000;
    cycle();
    in_valid3 = 1'b0;
    chk("c3_err_pulse", longint'(err_chan3), 1);
    chk("c3_err_stay_idle", longint'(in_ready3), 1);
    cycle();
    chk("c3_err_single", longint'(err_chan3), 0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid3 || !in_ready3 || err_chan3) quiet = 1'b0;
      cycle();
    end
    chk("c3_err_no_output", longint'(quiet), 1);
    send3(2, 0, got);
    chk("c3_ch2_hist_kept", got, -35);
    send3(1, 0, got);
    chk("c3_ch1_hist_kept", got, -20);
    send3(0, 2, got);
    chk("c3_ch0_fresh", got, 6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
